// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: state encoding and reset level shared by the pipeline stage register.
package pipe_stage_reg_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;
    localparam logic RST_EN = 1'b0;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/allowin pipeline stage register with flush.
// Define PIPE_SKID_BUF_EN for a two-entry skid buffer with a registered in_allowin_o.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W         = 128,
    parameter bit FLUSH_CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_allowin_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_allowin_i,
    output logic [1:0]        occ_o
);
    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic              in_xfer;

    assign out_data_o  = main_q;
    assign out_valid_o = state != EMPTY;
    assign occ_o       = state;
    assign in_xfer     = in_valid_i && in_allowin_o && !flush_i;

`ifdef PIPE_SKID_BUF_EN
    logic [DATA_W-1:0] skid_q;
    logic              allowin_q;
    logic              out_xfer;
    state_t            state_nxt;

    assign in_allowin_o = allowin_q;
    assign out_xfer     = out_valid_o && out_allowin_i;
    assign state_nxt    = flush_i         ? EMPTY :
                          state == EMPTY  ? (in_xfer ? BUSY : EMPTY) :
                          state == BUSY   ? ((in_xfer && !out_xfer) ? FULL :
                                             (out_xfer && !in_xfer) ? EMPTY : BUSY) :
                                            (out_xfer ? BUSY : FULL);

    // allowin is registered from the next state so out_allowin_i never reaches upstream combinationally
    always_ff @(posedge clk) begin
        if (rst_n == RST_EN) begin
            state     <= EMPTY;
            allowin_q <= 1'b1;
            main_q    <= '0;
            skid_q    <= '0;
        end else begin
            state     <= state_nxt;
            allowin_q <= state_nxt != FULL;
            if (flush_i && FLUSH_CLR_DATA) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (state == FULL && out_xfer)
                    main_q <= skid_q;
                else if (in_xfer && (state == EMPTY || out_xfer))
                    main_q <= in_data_i;
                if (in_xfer && state == BUSY && !out_xfer)
                    skid_q <= in_data_i;
            end
        end
    end
`else
    assign in_allowin_o = !out_valid_o || out_allowin_i;

    always_ff @(posedge clk) begin
        if (rst_n == RST_EN) begin
            state  <= EMPTY;
            main_q <= '0;
        end else if (flush_i) begin
            state <= EMPTY;
            if (FLUSH_CLR_DATA)
                main_q <= '0;
        end else if (in_allowin_o) begin
            state <= in_valid_i ? BUSY : EMPTY;
            if (in_xfer)
                main_q <= in_data_i;
        end
    end
`endif
endmodule
